// File: rtl/arbiter_pkg.sv
// arbiter_pkg: definitions shared by the arbiter and by the reorder/multiplex
// consumers of its tagged stream.
//   state_t : arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   idx_w   : requester-index width for N requesters (N >= 2)
//   tag_w   : width of a tagged beat {index, data}
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // A tagged beat is {index, data} with the index in the upper bits.
    function automatic int tag_w(input int n, input int w);
        return idx_w(n) + w;
    endfunction

endpackage

// File: rtl/arbiter_register.sv
// arbiter_register: one-entry stb/rdy output stage.
//   clk, rst       : clock, async active-low reset
//   s_stb/s_dat    : upstream beat, accepted when s_rdy
//   s_rdy          : ~m_stb | m_rdy (empty, or draining this cycle)
//   m_stb/m_dat    : registered beat, held stable until m_rdy
module arbiter_register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_stb,
    input  logic [WIDTH-1:0] s_dat,
    output logic             s_rdy,
    output logic             m_stb,
    output logic [WIDTH-1:0] m_dat,
    input  logic             m_rdy
);

    assign s_rdy = ~m_stb | m_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stb <= 1'b0;
            m_dat <= '0;
        end else if (s_stb && s_rdy) begin
            // A load while draining replaces the entry, so m_stb stays high.
            m_stb <= 1'b1;
            m_dat <= s_dat;
        end else if (m_rdy) begin
            m_stb <= 1'b0;
        end
    end

endmodule

// File: rtl/arbiter.sv
// arbiter: round-robin, burst-locking N:1 stb/rdy arbiter with a registered,
// index-tagged output.
//   clk, rst            : clock, async active-low reset
//   s_stb/s_dat/s_lst   : per-requester beat, requester i at s_dat[i*W +: W]
//   s_rdy               : per-requester accept, at most one bit set
//   m_stb/m_dat/m_lst   : registered output beat, m_dat = {index, data}
//   m_rdy               : downstream accept
module arbiter
    import arbiter_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_stb,
    input  logic [N*W-1:0]  s_dat,
    input  logic [N-1:0]    s_lst,
    output logic [N-1:0]    s_rdy,
    input  logic            m_rdy,
    output logic            m_stb,
    output logic [IW+W-1:0] m_dat,
    output logic            m_lst
);

    state_t        state, state_n;
    logic [IW-1:0] grant, grant_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] pick;
    logic          found;
    logic          reg_stb, reg_rdy;
    logic [IW+W:0] reg_in, reg_out;

    // Rotating priority: first requester at or after ptr, wrapping at N.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && s_stb[(int'(ptr) + k) % N]) begin
                pick  = IW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = ptr;
        s_rdy   = '0;
        reg_stb = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    grant_n = pick;
                end
            end
            GRANT: begin
                // The grant is held even if s_stb[grant] drops mid-burst;
                // only the last accepted beat releases it.
                s_rdy[grant] = reg_rdy;
                reg_stb      = s_stb[grant];
                if (s_stb[grant] && reg_rdy && s_lst[grant]) begin
                    state_n = IDLE;
                    ptr_n   = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register entry is {lst, index, data}.
    assign reg_in = {s_lst[grant], grant, s_dat[int'(grant)*W +: W]};

    arbiter_register #(
        .WIDTH(IW + W + 1)
    ) u_out (
        .clk  (clk),
        .rst  (rst),
        .s_stb(reg_stb),
        .s_dat(reg_in),
        .s_rdy(reg_rdy),
        .m_stb(m_stb),
        .m_dat(reg_out),
        .m_rdy(m_rdy)
    );

    assign m_lst = reg_out[IW+W];
    assign m_dat = reg_out[IW+W-1:0];

endmodule

// File: doc/arbiter.md
Name: arbiter

Overview:
- Round-robin, burst-locking arbiter that shares one stb/rdy stream, such as the write side of a reorder buffer or memory, between N requesters.
- Each requester presents W-bit beats plus a last flag.
- Once granted, a requester keeps the grant until its last beat is accepted.
- Output beats are registered and tagged with the requester index as {index, data}, matching the tagged-stream format used by the reorder/multiplex datapath.

Parameters:
W, 8, data width per requester.
N, 2, number of requesters; must be >= 2. Index width IW = $clog2(N).

Ports:
clk  input  1  clock; all state on the rising edge.
rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's job.
s_stb  input  N  per-requester beat valid.
s_dat  input  N*W  per-requester data; requester i occupies bits [i*W +: W].
s_lst  input  N  per-requester last-beat-of-burst flag, qualified by s_stb[i].
s_rdy  output  N  per-requester accept; at most one bit set (one-hot or zero).
m_rdy  input  1  downstream accept.
m_stb  output  1  output beat valid (registered).
m_dat  output  IW+W  {granted index, data} (registered).
m_lst  output  1  last flag of the output beat (registered).

Behaviour:
- Transfer rule: a transfer occurs on s_stb[i] & s_rdy[i], or on m_stb & m_rdy. Once s_stb is asserted, s_dat and s_lst are held until accepted.
- Reset (rst low, asynchronous): state=IDLE, grant=0, ptr=0, m_stb=0, m_lst=0, m_dat=0, s_rdy=0. Reset mid-burst discards the held output beat and the grant; no partial state survives.
- State IDLE:
  - s_rdy=0.
  - If any s_stb is set, select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Register it into grant; next state GRANT.
  - If no s_stb is set, stay in IDLE.
- State GRANT:
  - s_rdy[grant] = ~m_stb | m_rdy; all other s_rdy bits are 0.
  - On an accepted beat, load the output register: m_stb=1, m_dat={grant, s_dat[grant]}, m_lst=s_lst[grant].
  - If the accepted beat has s_lst=1: next state IDLE, ptr <= grant+1, wrapping N-1 -> 0.
  - If s_stb[grant] drops mid-burst: the grant is held and no other requester is served (no timeout).
- Output register:
  - m_stb clears on m_stb & m_rdy when no new beat is loaded that cycle.
  - When m_rdy and a new accept occur in the same cycle, the register is replaced and m_stb stays 1.
  - While m_stb=1 and m_rdy=0, m_dat and m_lst are stable.
- Latency and throughput:
  - A request in IDLE at cycle t gives s_rdy at t+1 and m_stb at t+2.
  - Within a burst: 1 beat/cycle at full m_rdy.
  - Exactly one bubble (the IDLE arbitration cycle) between consecutive bursts.
- Fairness: a requester continuously asserting s_stb waits at most N-1 other bursts before its grant.
- Single-beat burst (s_lst=1 on first beat): GRANT lasts one accepting cycle.
- Requests arriving during GRANT from other requesters are ignored until IDLE; no request is lost, since stb is held.

Decomposition:
- Shared package / header:
  - State encoding localparams IDLE=1'b0, GRANT=1'b1.
  - IW computation and the tagged-beat layout {index, data}, so that reorder/multiplex consumers share one definition.
- One sub-module, `register`:
  - One-entry stb/rdy output stage: parameter width; ports clk, rst, s_stb, s_dat, s_rdy, m_stb, m_dat, m_rdy.
  - It carries {lst, index, data} and implements s_rdy = ~m_stb | m_rdy.
- The arbiter top holds the FSM, ptr, grant and the rotating priority scan.

Test Plan:
1. Reset: N=2, W=8. Drive rst low mid-burst, with m_stb=1 and grant=1 -> m_stb, s_rdy and m_lst go 0 immediately without a clock edge. After release, the first grant goes to requester 0 when both request.
2. Round robin: N=4, all s_stb=1, single-beat bursts (s_lst=1), requester i data=8'h10+i, m_rdy=1 -> m_dat sequence {0,10},{1,11},{2,12},{3,13},{0,10}, with one m_stb bubble between beats.
3. Burst lock: requester 1 sends 3 beats AA,BB,CC (lst on CC) while requester 0 requests throughout -> output {1,AA},{1,BB},{1,CC} on consecutive cycles, then {0,...}. s_rdy[0]=0 during the burst.
4. Backpressure: m_rdy=0 for 5 cycles mid-burst -> m_stb=1 and m_dat stable. s_rdy[grant]=0 after the register fills. Raising m_rdy resumes 1 beat/cycle with no loss or duplication.
5. Wrap and gap: N=3, ptr=2, only requester 0 requests -> grant 0, and ptr becomes 1 after its last beat. Requester 0 drops s_stb for 2 cycles mid-burst while requester 2 requests -> grant stays 0 until the lst beat.
